ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_pkg.sv | 60 ++++++
 rtl/ctrl_seq_insn_decode.sv | 74 +++++++
 rtl/ctrl_seq.sv | 97 +++++++++
 tb/tb_ctrl_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg -- shared constants and types for the ctrl_seq controller.
//
// Contents:
//   ALU_MODE_COUNT and the one-hot bit index of each ALU operation
//   4-bit opcode constants
//   FSM state encodings (FETCH, EXEC, HALT)
//   ctrl_t: decoded control bundle passed from insn_decode to ctrl_seq
//   alu_onehot(): builds a one-hot ALU select from a bit index
//
// Configuration: WF8_BRANCH_EN (see insn_decode) enables JMP/BZ.
package ctrl_seq_pkg;

    localparam int ALU_MODE_COUNT    = 7;
    localparam int ALU_MODE_ADD      = 0;
    localparam int ALU_MODE_SHIFT    = 1;
    localparam int ALU_MODE_NOT      = 2;
    localparam int ALU_MODE_AND      = 3;
    localparam int ALU_MODE_OR       = 4;
    localparam int ALU_MODE_BYPASS_A = 5;
    localparam int ALU_MODE_BYPASS_B = 6;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SH   = 4'h3;
    localparam logic [3:0] OP_SHI  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_MVA  = 4'h8;
    localparam logic [3:0] OP_MVR  = 4'h9;
    localparam logic [3:0] OP_LI   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BZ   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef struct packed {
        logic [ALU_MODE_COUNT-1:0] alu_mode;
        logic                      a_sel_pc;
        logic                      b_sel_imm;
        logic                      acc_we;
        logic                      reg_we;
        logic                      pc_we;
        logic                      pc_inc;
        logic                      illegal;
        logic                      halt;
    } ctrl_t;

    function automatic logic [ALU_MODE_COUNT-1:0] alu_onehot(input int idx);
        logic [ALU_MODE_COUNT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ctrl_seq_insn_decode.sv
// insn_decode -- purely combinational opcode-to-control mapping.
//
// Ports:
//   op_i       [3:0]  latched opcode field
//   rs_i       [2:0]  latched register field
//   acc_zero_i        accumulator-is-zero flag (BZ condition)
//   ctrl_o            decoded control bundle (ctrl_t), not gated by FSM state
//
// Configuration: WF8_BRANCH_EN defined enables JMP (B) and BZ (C);
// undefined, both decode as illegal and pc_we is never produced.
module insn_decode
    import ctrl_seq_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [2:0] rs_i,
    input  logic       acc_zero_i,
    output ctrl_t      ctrl_o
);

    logic reg_form;
    logic bad;

`ifndef WF8_BRANCH_EN
    // The branch condition has no consumer without branches.
    logic unused_acc_zero;
    assign unused_acc_zero = acc_zero_i;
`endif

    always_comb begin
        ctrl_o   = '0;
        reg_form = 1'b0;
        bad      = 1'b0;
        case (op_i)
            OP_NOP:  ;
            OP_ADD:  begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_ADD);      ctrl_o.acc_we = 1'b1; reg_form = 1'b1; end
            OP_ADDI: begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_ADD);      ctrl_o.acc_we = 1'b1; ctrl_o.b_sel_imm = 1'b1; end
            OP_SH:   begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_SHIFT);    ctrl_o.acc_we = 1'b1; reg_form = 1'b1; end
            OP_SHI:  begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_SHIFT);    ctrl_o.acc_we = 1'b1; ctrl_o.b_sel_imm = 1'b1; end
            OP_NOT:  begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_NOT);      ctrl_o.acc_we = 1'b1; end
            OP_AND:  begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_AND);      ctrl_o.acc_we = 1'b1; reg_form = 1'b1; end
            OP_OR:   begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_OR);       ctrl_o.acc_we = 1'b1; reg_form = 1'b1; end
            OP_MVA:  begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_A); ctrl_o.reg_we = 1'b1; reg_form = 1'b1; end
            OP_MVR:  begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_B); ctrl_o.acc_we = 1'b1; reg_form = 1'b1; end
            OP_LI:   begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_B); ctrl_o.acc_we = 1'b1; ctrl_o.b_sel_imm = 1'b1; end
`ifdef WF8_BRANCH_EN
            OP_JMP:  begin ctrl_o.alu_mode = alu_onehot(ALU_MODE_BYPASS_A); ctrl_o.pc_we = 1'b1; end
            OP_BZ: begin
                // Target is PC + imm; only the write is conditional.
                ctrl_o.alu_mode  = alu_onehot(ALU_MODE_ADD);
                ctrl_o.a_sel_pc  = 1'b1;
                ctrl_o.b_sel_imm = 1'b1;
                ctrl_o.pc_we     = acc_zero_i;
            end
`endif
            OP_HALT: ctrl_o.halt = 1'b1;
            default: bad = 1'b1;
        endcase

        // x7 does not exist; register forms naming it are rejected.
        if (reg_form && rs_i == 3'd7) begin
            bad = 1'b1;
        end

        // Sequential PC advance unless the PC is being loaded or we stop.
        ctrl_o.pc_inc = ~(ctrl_o.pc_we | ctrl_o.halt);

        if (bad) begin
            ctrl_o         = '0;
            ctrl_o.illegal = 1'b1;
            ctrl_o.pc_inc  = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq -- fetch/execute control sequencer for an 8-bit accumulator core.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   imem_req / imem_ack      fetch handshake; imem_rdata = {opcode, operand}
//   acc_zero                 accumulator zero flag, used by BZ in EXEC only
//   alu_mode                 one-hot ALU select (EXEC only)
//   a_sel_pc, b_sel_imm      ALU operand selects
//   rs_addr, imm             latched [2:0] and [3:0] of the instruction
//   acc_we, reg_we, pc_we, pc_inc  writeback strobes (EXEC only)
//   halted, illegal          halt level, illegal-opcode pulse
//
// Configuration: WF8_BRANCH_EN enables JMP/BZ (decoded in insn_decode).
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int BIT_COUNT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    input  logic                      imem_ack,
    input  logic [BIT_COUNT-1:0]      imem_rdata,
    input  logic                      acc_zero,
    output logic [ALU_MODE_COUNT-1:0] alu_mode,
    output logic                      a_sel_pc,
    output logic                      b_sel_imm,
    output logic [2:0]                rs_addr,
    output logic [3:0]                imm,
    output logic                      acc_we,
    output logic                      reg_we,
    output logic                      pc_we,
    output logic                      pc_inc,
    output logic                      halted,
    output logic                      illegal
);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [BIT_COUNT-1:0] insn_q;
    logic [BIT_COUNT-1:0] insn_d;
    ctrl_t                dec;
    logic                 in_exec;

    insn_decode u_decode (
        .op_i       (insn_q[7:4]),
        .rs_i       (insn_q[2:0]),
        .acc_zero_i (acc_zero),
        .ctrl_o     (dec)
    );

    always_comb begin
        state_d = state_q;
        insn_d  = insn_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    insn_d  = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = dec.halt ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            insn_q  <= '0;
        end else begin
            state_q <= state_d;
            insn_q  <= insn_d;
        end
    end

    // Outputs are gated with rst directly: the register already sits in
    // FETCH during reset, but nothing (not even imem_req) may be visible.
    assign in_exec   = (state_q == ST_EXEC) && !rst;
    assign imem_req  = (state_q == ST_FETCH) && !rst;
    assign halted    = (state_q == ST_HALT) && !rst;

    assign alu_mode  = in_exec ? dec.alu_mode : '0;
    assign a_sel_pc  = in_exec & dec.a_sel_pc;
    assign b_sel_imm = in_exec & dec.b_sel_imm;
    assign acc_we    = in_exec & dec.acc_we;
    assign reg_we    = in_exec & dec.reg_we;
    assign pc_we     = in_exec & dec.pc_we;
    assign pc_inc    = in_exec & dec.pc_inc;
    assign illegal   = in_exec & dec.illegal;

    // insn_q is cleared asynchronously, so these read 0 during reset.
    assign rs_addr   = insn_q[2:0];
    assign imm       = insn_q[3:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq -- self-checking bench for ctrl_seq (randomized + directed).
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       acc_zero;
    logic [6:0] alu_mode;
    logic       a_sel_pc, b_sel_imm;
    logic [2:0] rs_addr;
    logic [3:0] imm;
    logic       acc_we, reg_we, pc_we, pc_inc;
    logic       halted, illegal;

    int checks   = 0;
    int failures = 0;

    ctrl_seq #(.BIT_COUNT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .acc_zero   (acc_zero),
        .alu_mode   (alu_mode),
        .a_sel_pc   (a_sel_pc),
        .b_sel_imm  (b_sel_imm),
        .rs_addr    (rs_addr),
        .imm        (imm),
        .acc_we     (acc_we),
        .reg_we     (reg_we),
        .pc_we      (pc_we),
        .pc_inc     (pc_inc),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // {alu_mode, a_sel_pc, b_sel_imm, acc_we, reg_we, pc_we, pc_inc, illegal}
    wire [13:0] obs     = {alu_mode, a_sel_pc, b_sel_imm, acc_we, reg_we, pc_we, pc_inc, illegal};
    wire [11:0] quiet   = {alu_mode, acc_we, reg_we, pc_we, pc_inc, illegal};
    wire [24:0] all_out = {imem_req, alu_mode, a_sel_pc, b_sel_imm, rs_addr, imm,
                           acc_we, reg_we, pc_we, pc_inc, halted, illegal};

    // Reference: what the EXEC cycle of one instruction must show.
    function automatic logic [13:0] model(input logic [7:0] ins, input logic az);
        logic [3:0] op;
        logic [2:0] rs;
        logic [6:0] mode;
        int  alu;
        bit  asel, bsel, wacc, wreg, wpc, regform, legal, halt;
        op = ins[7:4];
        rs = ins[2:0];
        alu = -1; asel = 0; bsel = 0; wacc = 0; wreg = 0; wpc = 0;
        regform = 0; legal = 1; halt = 0;
        case (op)
            4'h0: ;
            4'h1: begin alu = 0; wacc = 1; regform = 1; end
            4'h2: begin alu = 0; wacc = 1; bsel = 1; end
            4'h3: begin alu = 1; wacc = 1; regform = 1; end
            4'h4: begin alu = 1; wacc = 1; bsel = 1; end
            4'h5: begin alu = 2; wacc = 1; end
            4'h6: begin alu = 3; wacc = 1; regform = 1; end
            4'h7: begin alu = 4; wacc = 1; regform = 1; end
            4'h8: begin alu = 5; wreg = 1; regform = 1; end
            4'h9: begin alu = 6; wacc = 1; regform = 1; end
            4'hA: begin alu = 6; wacc = 1; bsel = 1; end
`ifdef WF8_BRANCH_EN
            4'hB: begin alu = 5; wpc = 1; end
            4'hC: begin alu = 0; asel = 1; bsel = 1; wpc = az; end
`else
            4'hB, 4'hC: legal = 0;
`endif
            4'hF: halt = 1;
            default: legal = 0;
        endcase
        if (regform && rs == 3'd7) legal = 0;
        if (!legal) return 14'b0000000_0000011;
        mode = '0;
        if (alu >= 0) mode[alu] = 1'b1;
        return {mode, asel, bsel, wacc, wreg, wpc, !(wpc || halt), 1'b0};
    endfunction

    // Drive one fetch (with stall cycles) and the following EXEC cycle.
    // Starts and ends 1 time unit after a rising edge.
    task automatic run_insn(input logic [7:0] ins, input logic az, input int stall,
                            input bit junk, output logic [13:0] o, output logic [2:0] rs,
                            output logic [3:0] im, output int req_cnt, output bit seq_bad);
        req_cnt = 0;
        seq_bad = 0;
        for (int i = 0; i <= stall; i++) begin
            imem_ack   = (i == stall);
            imem_rdata = (i == stall) ? ins : 8'($urandom);
            acc_zero   = 1'($urandom);
            @(negedge clk);
            if (imem_req) req_cnt++;
            if (quiet != 0 || halted) seq_bad = 1;
            @(posedge clk); #1;
        end
        imem_ack   = junk;   // must be ignored in EXEC
        imem_rdata = ~ins;
        acc_zero   = az;
        @(negedge clk);
        o  = obs;
        rs = rs_addr;
        im = imm;
        if (imem_req || halted) seq_bad = 1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (all_out !== 25'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
        @(posedge clk); #1;
        checks++;
        if (all_out !== 25'd0) begin failures++; $display("FAIL reset_held got=%h exp=0", all_out); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || halted !== 1'b0 || quiet !== 12'd0) begin
            failures++; $display("FAIL reset_release req=%b halted=%b quiet=%h exp req=1", imem_req, halted, quiet);
        end
        @(posedge clk); #1;
        $display("txn reset done");
    endtask

    task automatic test_fetch_stall;
        logic [13:0] o; logic [2:0] rs; logic [3:0] im; int rc; bit bad;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        run_insn(8'h12, 1'b0, 3, 1'b0, o, rs, im, rc, bad);
        $display("txn fetch_stall ins=12 req_cycles=%0d", rc);
        checks++;
        if (rc !== 4 || bad) begin failures++; $display("FAIL stall_req got=%0d bad=%0d exp=4", rc, bad); end
        checks++;
        if (o !== 14'b0000001_0010010) begin failures++; $display("FAIL stall_exec got=%b exp=%b", o, 14'b0000001_0010010); end
        checks++;
        if (rs !== 3'd2) begin failures++; $display("FAIL stall_rs got=%0d exp=2", rs); end
    endtask

    task automatic test_immediate;
        logic [13:0] o; logic [2:0] rs; logic [3:0] im; int rc; bit bad;
        run_insn(8'hA5, 1'b0, 0, 1'b1, o, rs, im, rc, bad);
        $display("txn immediate ins=a5 obs=%b imm=%0d", o, im);
        checks++;
        if (o !== 14'b1000000_0110010) begin failures++; $display("FAIL imm_exec got=%b exp=%b", o, 14'b1000000_0110010); end
        checks++;
        if (im !== 4'd5) begin failures++; $display("FAIL imm_field got=%0d exp=5", im); end
    endtask

    task automatic test_branch;
        logic [13:0] o; logic [2:0] rs; logic [3:0] im; int rc; bit bad;
        logic [13:0] e1, e0;
`ifdef WF8_BRANCH_EN
        e1 = 14'b0000001_1100100;
        e0 = 14'b0000001_1100010;
`else
        e1 = 14'b0000000_0000011;
        e0 = 14'b0000000_0000011;
`endif
        run_insn(8'hC3, 1'b1, 1, 1'b0, o, rs, im, rc, bad);
        $display("txn branch ins=c3 az=1 obs=%b", o);
        checks++;
        if (o !== e1) begin failures++; $display("FAIL bz_taken got=%b exp=%b", o, e1); end
        run_insn(8'hC3, 1'b0, 0, 1'b0, o, rs, im, rc, bad);
        $display("txn branch ins=c3 az=0 obs=%b", o);
        checks++;
        if (o !== e0) begin failures++; $display("FAIL bz_not_taken got=%b exp=%b", o, e0); end
    endtask

    task automatic test_illegal;
        logic [13:0] o; logic [2:0] rs; logic [3:0] im; int rc; bit bad;
        logic [7:0] list [2];
        list[0] = 8'h17; list[1] = 8'hD0;
        for (int k = 0; k < 2; k++) begin
            run_insn(list[k], 1'($urandom), 0, 1'b0, o, rs, im, rc, bad);
            $display("txn illegal ins=%h obs=%b", list[k], o);
            checks++;
            if (o !== 14'b0000000_0000011) begin
                failures++; $display("FAIL illegal_exec ins=%h got=%b exp=%b", list[k], o, 14'b0000000_0000011);
            end
            @(negedge clk);
            checks++;
            if (illegal !== 1'b0 || imem_req !== 1'b1) begin
                failures++; $display("FAIL illegal_pulse ins=%h got ill=%b req=%b exp ill=0 req=1", list[k], illegal, imem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input int n, input bit b2b);
        logic [13:0] o, e; logic [2:0] rs; logic [3:0] im; int rc, st; bit bad, az, junk;
        logic [7:0] ins;
        for (int t = 0; t < n; t++) begin
            do ins = 8'($urandom); while (ins[7:4] == 4'hF);
            az   = 1'($urandom);
            st   = b2b ? 0 : int'($urandom_range(0, 3));
            junk = b2b ? 1'b1 : 1'($urandom);
            e = model(ins, az);
            run_insn(ins, az, st, junk, o, rs, im, rc, bad);
            $display("txn %s ins=%h az=%0d stall=%0d obs=%b exp=%b", b2b ? "b2b" : "rand", ins, az, st, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL rand_ctrl ins=%h got=%b exp=%b", ins, o, e); end
            checks++;
            if (rs !== ins[2:0] || im !== ins[3:0]) begin
                failures++; $display("FAIL rand_fields ins=%h got rs=%0d imm=%0d", ins, rs, im);
            end
            checks++;
            if (rc !== st + 1 || bad) begin
                failures++; $display("FAIL rand_handshake ins=%h got req=%0d bad=%0d exp req=%0d", ins, rc, bad, st + 1);
            end
        end
    endtask

    task automatic test_halt;
        logic [13:0] o; logic [2:0] rs; logic [3:0] im; int rc; bit bad; int errs;
        run_insn(8'hF0, 1'($urandom), 0, 1'b0, o, rs, im, rc, bad);
        $display("txn halt ins=f0 obs=%b", o);
        checks++;
        if (o !== 14'd0) begin failures++; $display("FAIL halt_exec got=%b exp=0", o); end
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            imem_ack = 1'b1; imem_rdata = 8'($urandom);
            @(negedge clk);
            if (halted !== 1'b1 || imem_req !== 1'b0 || quiet !== 12'd0) errs++;
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        checks++;
        if (errs != 0) begin failures++; $display("FAIL halt_hold bad_cycles=%0d exp=0", errs); end
        rst = 1'b1; #1;
        checks++;
        if (all_out !== 25'd0) begin failures++; $display("FAIL halt_reset got=%h exp=0", all_out); end
        @(posedge clk); #1; rst = 1'b0; #1;
        checks++;
        if (imem_req !== 1'b1 || halted !== 1'b0) begin
            failures++; $display("FAIL halt_exit got req=%b halted=%b exp req=1 halted=0", imem_req, halted);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_exec;
        imem_ack = 1'b1; imem_rdata = 8'h81;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        checks++;
        if (reg_we !== 1'b1) begin failures++; $display("FAIL mva_exec reg_we got=%b exp=1", reg_we); end
        rst = 1'b1; #1;
        $display("txn reset_mid_exec ins=81 outputs=%h", all_out);
        checks++;
        if (all_out !== 25'd0) begin failures++; $display("FAIL mid_exec_reset got=%h exp=0", all_out); end
        @(posedge clk); #1; rst = 1'b0; #1;
        checks++;
        if (imem_req !== 1'b1 || quiet !== 12'd0 || rs_addr !== 3'd0) begin
            failures++; $display("FAIL mid_exec_release req=%b quiet=%h rs=%0d exp req=1", imem_req, quiet, rs_addr);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 8'h00; acc_zero = 1'b0;
        test_reset;
        test_fetch_stall;
        test_immediate;
        test_branch;
        test_illegal;
        test_random(40, 1'b0);
        test_random(20, 1'b1);
        test_halt;
        test_reset_mid_exec;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
